// File: rtl/ex_mem_buffer_if.sv
// EX/MEM pipeline bus: EX-side inputs, control requests, registered memory-stage
// outputs and the upstream stall/interrupt-acknowledge signals.
interface ex_mem_buffer_if;
    logic [15:0] ex_ALU_result;
    logic [15:0] ex_Rsrc_value;
    logic [15:0] ex_Rdst_value;
    logic [2:0]  ex_Rdst_address;
    logic        ex_memRead;
    logic        ex_memWrite;
    logic        ex_WB;
    logic        ex_push;
    logic        ex_pop;
    logic [15:0] ex_pc;
    logic [2:0]  ex_flagReg;
    logic        flush;
    logic        intr;

    logic [15:0] ALU_result;
    logic [15:0] Rsrc_value;
    logic [15:0] Rdst_value;
    logic [2:0]  Rdst_address;
    logic        memRead;
    logic        memWrite;
    logic        WB;
    logic        push;
    logic        pop;
    logic        pushPc;
    logic        pushCCR;
    logic [15:0] pc;
    logic [2:0]  flagReg;
    logic [1:0]  shmnt_mem;
    logic        stall;
    logic        intAck;

    modport slave (
        input  ex_ALU_result, ex_Rsrc_value, ex_Rdst_value, ex_Rdst_address,
               ex_memRead, ex_memWrite, ex_WB, ex_push, ex_pop, ex_pc, ex_flagReg,
               flush, intr,
        output ALU_result, Rsrc_value, Rdst_value, Rdst_address,
               memRead, memWrite, WB, push, pop, pushPc, pushCCR,
               pc, flagReg, shmnt_mem, stall, intAck
    );

    modport master (
        output ex_ALU_result, ex_Rsrc_value, ex_Rdst_value, ex_Rdst_address,
               ex_memRead, ex_memWrite, ex_WB, ex_push, ex_pop, ex_pc, ex_flagReg,
               flush, intr,
        input  ALU_result, Rsrc_value, Rdst_value, Rdst_address,
               memRead, memWrite, WB, push, pop, pushPc, pushCCR,
               pc, flagReg, shmnt_mem, stall, intAck
    );
endinterface

// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline register with an interrupt push sequencer (PC push, then CCR push).
// Macro INT_PUSH_CCR_EN enables the CCR push cycle; undefined gives a single PC push.
module ex_mem_buffer (
    input  logic                clk,
    input  logic                rst,
    ex_mem_buffer_if.slave      bus
);

    typedef struct packed {
        logic [15:0] alu_result;
        logic [15:0] rsrc_value;
        logic [15:0] rdst_value;
        logic [2:0]  rdst_address;
        logic        mem_read;
        logic        mem_write;
        logic        wb;
        logic        push;
        logic        pop;
        logic        push_pc;
        logic        push_ccr;
        logic [15:0] pc;
        logic [2:0]  flag_reg;
        logic [1:0]  shmnt_mem;
    } bundle_t;

    // State names the bundle currently sitting on the outputs.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] S_PC  = 2'd1;
`ifdef INT_PUSH_CCR_EN
    localparam logic [1:0] S_CCR = 2'd2;
`endif

    logic [1:0] state_d, state_q;
    bundle_t    bundle_d, bundle_q;
    bundle_t    capture_b;
    bundle_t    pc_push_b;
`ifdef INT_PUSH_CCR_EN
    logic [2:0] ccr_d, ccr_q;
    bundle_t    ccr_push_b;
`endif

    // Normal capture of the EX slot; a flush turns it into an all-zero bubble.
    always_comb begin
        capture_b = '0;
        if (!bus.flush) begin
            capture_b.alu_result   = bus.ex_ALU_result;
            capture_b.rsrc_value   = bus.ex_Rsrc_value;
            capture_b.rdst_value   = bus.ex_Rdst_value;
            capture_b.rdst_address = bus.ex_Rdst_address;
            capture_b.mem_read     = bus.ex_memRead;
            capture_b.mem_write    = bus.ex_memWrite;
            capture_b.wb           = bus.ex_WB;
            capture_b.push         = bus.ex_push;
            capture_b.pop          = bus.ex_pop;
            capture_b.pc           = bus.ex_pc;
            capture_b.flag_reg     = bus.ex_flagReg;
        end
    end

    always_comb begin
        pc_push_b           = '0;
        pc_push_b.push      = 1'b1;
        pc_push_b.mem_write = 1'b1;
        pc_push_b.push_pc   = 1'b1;
        pc_push_b.pc        = bus.ex_pc;
        pc_push_b.shmnt_mem = 2'b01;
    end

`ifdef INT_PUSH_CCR_EN
    always_comb begin
        ccr_push_b           = '0;
        ccr_push_b.push      = 1'b1;
        ccr_push_b.mem_write = 1'b1;
        ccr_push_b.push_ccr  = 1'b1;
        ccr_push_b.flag_reg  = ccr_q;
        ccr_push_b.shmnt_mem = 2'b10;
    end
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        state_d  = IDLE;
        bundle_d = capture_b;
`ifdef INT_PUSH_CCR_EN
        ccr_d    = ccr_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.intr) begin
                    state_d  = S_PC;
                    bundle_d = pc_push_b;
`ifdef INT_PUSH_CCR_EN
                    ccr_d    = bus.ex_flagReg;
`endif
                end
            end
`ifdef INT_PUSH_CCR_EN
            S_PC: begin
                state_d  = S_CCR;
                bundle_d = ccr_push_b;
            end
`endif
            default: begin
                state_d  = IDLE;
                bundle_d = capture_b;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= IDLE;
            bundle_q <= '0;
`ifdef INT_PUSH_CCR_EN
            ccr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
`ifdef INT_PUSH_CCR_EN
            ccr_q    <= ccr_d;
`endif
        end
    end

    assign bus.ALU_result   = bundle_q.alu_result;
    assign bus.Rsrc_value   = bundle_q.rsrc_value;
    assign bus.Rdst_value   = bundle_q.rdst_value;
    assign bus.Rdst_address = bundle_q.rdst_address;
    assign bus.memRead      = bundle_q.mem_read;
    assign bus.memWrite     = bundle_q.mem_write;
    assign bus.WB           = bundle_q.wb;
    assign bus.push         = bundle_q.push;
    assign bus.pop          = bundle_q.pop;
    assign bus.pushPc       = bundle_q.push_pc;
    assign bus.pushCCR      = bundle_q.push_ccr;
    assign bus.pc           = bundle_q.pc;
    assign bus.flagReg      = bundle_q.flag_reg;
    assign bus.shmnt_mem    = bundle_q.shmnt_mem;

`ifdef INT_PUSH_CCR_EN
    assign bus.stall  = (state_q == S_PC) || (state_q == S_CCR);
    assign bus.intAck = (state_q == S_CCR);
`else
    // Single push cycle: the EX instruction keeps flowing while the PC is pushed.
    assign bus.stall  = 1'b0;
    assign bus.intAck = (state_q == S_PC);
`endif

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed-vector bench for ex_mem_buffer; follows INT_PUSH_CCR_EN the same way the RTL does.
module tb_ex_mem_buffer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ex_mem_buffer_if bus ();

    ex_mem_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic [15:0] alu, input logic [15:0] src, input logic [15:0] dst,
                            input logic [2:0] addr, input logic mr, input logic mw, input logic wb,
                            input logic ps, input logic pp, input logic [15:0] pcv, input logic [2:0] flg);
        bus.ex_ALU_result   = alu;
        bus.ex_Rsrc_value   = src;
        bus.ex_Rdst_value   = dst;
        bus.ex_Rdst_address = addr;
        bus.ex_memRead      = mr;
        bus.ex_memWrite     = mw;
        bus.ex_WB           = wb;
        bus.ex_push         = ps;
        bus.ex_pop          = pp;
        bus.ex_pc           = pcv;
        bus.ex_flagReg      = flg;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, {bus.ALU_result, bus.Rsrc_value}, 32'h0);
        check({tag, "_dst"}, {bus.Rdst_value, bus.pc}, 32'h0);
        check({tag, "_ctl"}, {bus.Rdst_address, bus.memRead, bus.memWrite, bus.WB, bus.push,
                              bus.pop, bus.pushPc, bus.pushCCR, bus.flagReg, bus.shmnt_mem}, 32'h0);
        check({tag, "_stall"}, bus.stall, 1'b0);
        check({tag, "_intAck"}, bus.intAck, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus.flush = 1'b0;
        bus.intr  = 1'b0;
        drive_ex(16'hffff, 16'h1111, 16'h2222, 3'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h00aa, 3'b111);
        tick();
        tick();
        check_all_zero("reset");

        // Normal capture, one-cycle latency.
        rst = 1'b0;
        drive_ex(16'h1234, 16'h5678, 16'h9abc, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 3'b011);
        tick();
        check("cap_alu", bus.ALU_result, 16'h1234);
        check("cap_src_dst", {bus.Rsrc_value, bus.Rdst_value}, 32'h5678_9abc);
        check("cap_wb", bus.WB, 1'b1);
        check("cap_addr", bus.Rdst_address, 3'd3);
        check("cap_pop_push", {bus.pop, bus.push, bus.pushPc, bus.pushCCR}, 4'b1000);
        check("cap_pc_flag", {bus.pc, 13'h0, bus.flagReg}, {16'h0010, 13'h0, 3'b011});
        check("cap_shmnt", bus.shmnt_mem, 2'b00);
        check("cap_stall", {bus.stall, bus.intAck}, 2'b00);

        // Flush loads a bubble.
        bus.flush = 1'b1;
        drive_ex(16'h4321, 16'h0, 16'h0, 3'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0020, 3'b001);
        tick();
        check("flush_ctl", {bus.memRead, bus.memWrite, bus.WB, bus.push, bus.pop}, 5'b0);
        check("flush_alu", bus.ALU_result, 16'h0);

        // Interrupt with flush in IDLE: interrupt wins, PC-push bundle.
        bus.intr = 1'b1;
        drive_ex(16'h7777, 16'h0, 16'h0, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 3'b101);
        tick();
        check("pc_push_ctl", {bus.push, bus.memWrite, bus.pushPc, bus.pushCCR, bus.pop, bus.memRead, bus.WB},
              7'b1110000);
        check("pc_push_pc", bus.pc, 16'h0040);
        check("pc_push_shmnt", bus.shmnt_mem, 2'b01);
        check("pc_push_alu", bus.ALU_result, 16'h0);
`ifdef INT_PUSH_CCR_EN
        check("pc_push_hs", {bus.stall, bus.intAck}, 2'b10);
        // Flush and intr held in S_PC are ignored; CCR bundle still loads.
        drive_ex(16'h0bad, 16'h0, 16'h0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0044, 3'b000);
        tick();
        check("ccr_push_ctl", {bus.push, bus.memWrite, bus.pushPc, bus.pushCCR, bus.pop, bus.memRead, bus.WB},
              7'b1101000);
        check("ccr_push_flag", bus.flagReg, 3'b101);
        check("ccr_push_shmnt", bus.shmnt_mem, 2'b10);
        check("ccr_push_hs", {bus.stall, bus.intAck}, 2'b11);
`else
        check("pc_push_hs", {bus.stall, bus.intAck}, 2'b01);
`endif
        // Resume edge: intr still high but ignored, normal capture back to IDLE.
        bus.flush = 1'b0;
        drive_ex(16'habcd, 16'h0001, 16'h0002, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0048, 3'b010);
        tick();
        check("resume_alu", bus.ALU_result, 16'habcd);
        check("resume_ctl", {bus.WB, bus.push, bus.pushPc, bus.pushCCR, bus.shmnt_mem}, 6'b100000);
        check("resume_hs", {bus.stall, bus.intAck}, 2'b00);

        // intr still high is sampled again in IDLE and restarts the sequence.
        drive_ex(16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0050, 3'b110);
        tick();
        check("restart_pc", {bus.pushPc, bus.push, bus.pc}, {1'b1, 1'b1, 16'h0050});

        // Reset mid-sequence (in S_PC) with intr high.
        rst = 1'b1;
        tick();
        check_all_zero("rst_mid");

        // After reset, a fresh interrupt starts from the PC push.
        rst = 1'b0;
        drive_ex(16'h0, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0100, 3'b010);
        tick();
        check("post_rst_pc", {bus.pushPc, bus.pushCCR, bus.pc}, {1'b1, 1'b0, 16'h0100});
        bus.intr = 1'b0;
`ifdef INT_PUSH_CCR_EN
        tick();
        check("post_rst_ccr", {bus.pushCCR, bus.flagReg}, {1'b1, 3'b010});
`endif
        drive_ex(16'h5a5a, 16'h0, 16'h0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0104, 3'b001);
        tick();
        check("post_rst_resume", {bus.ALU_result, bus.memRead, bus.WB, bus.pushPc, bus.pushCCR},
              {16'h5a5a, 1'b1, 1'b1, 1'b0, 1'b0});
        tick();
        check("idle_hold", {bus.stall, bus.intAck, bus.push}, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
